// File: rtl/bsg_manycore_endpoint_store_unit_pkg.sv
// Shared packet definitions for the manycore endpoint store unit: op codes,
// the config freeze address, the packet width helper and the head decoder.
package bsg_manycore_endpoint_store_unit_pkg;

  localparam int op_width_gp = 2;

  localparam logic [op_width_gp-1:0] op_store_gp  = 2'd1;
  localparam logic [op_width_gp-1:0] op_config_gp = 2'd2;

  localparam int config_freeze_addr_gp = 0;

  typedef enum logic [1:0] {
    e_dec_none,
    e_dec_store,
    e_dec_config,
    e_dec_unknown
  } decode_e;

  // Packet layout, MSB to LSB: op, op_ex (byte mask), addr, data, from_y_cord, from_x_cord.
  function automatic int packet_width(input int addr_w, input int data_w,
                                      input int x_w, input int y_w);
    return op_width_gp + (data_w / 8) + addr_w + data_w + y_w + x_w;
  endfunction

  function automatic decode_e decode_op(input logic v,
                                        input logic [op_width_gp-1:0] op,
                                        input logic addr_is_freeze);
    decode_e d;
    d = e_dec_none;
    if (v) begin
      if (op == op_store_gp)
        d = e_dec_store;
      else if ((op == op_config_gp) && addr_is_freeze)
        d = e_dec_config;
      else
        d = e_dec_unknown;
    end
    return d;
  endfunction

endpackage

// File: rtl/bsg_manycore_endpoint_store_unit_two_fifo.sv
// Two-entry FIFO for the incoming packet buffer; sustains one packet per cycle
// when the head is dequeued every cycle.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] w_slot [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  assign ready_o = (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;
  assign data_o  = w_slot[r_rptr];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [width_p-1:0] r_data;
      always_ff @(posedge clk_i) begin
        if (w_enq && (r_wptr == 1'(gi)))
          r_data <= data_i;
      end
      assign w_slot[gi] = r_data;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq)
        r_wptr <= ~r_wptr;
      if (w_deq)
        r_rptr <= ~r_rptr;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bsg_manycore_endpoint_store_unit.sv
// Tile-side endpoint: buffers network packets, issues masked stores to local
// memory, owns the freeze register and a saturating unknown-packet counter.
// Define BSG_MANYCORE_ENDPOINT_RETURN_CREDIT_EN to add the returning-credit outputs.
module bsg_manycore_endpoint_store_unit
  import bsg_manycore_endpoint_store_unit_pkg::*;
#(
  parameter int x_cord_width_p      = 4,
  parameter int y_cord_width_p      = 4,
  parameter int data_width_p        = 32,
  parameter int addr_width_p        = 10,
  parameter int unknown_cnt_width_p = 8,
  parameter bit freeze_init_p       = 1'b1,
  localparam int packet_width_lp    = packet_width(addr_width_p, data_width_p,
                                                   x_cord_width_p, y_cord_width_p),
  localparam int mask_width_lp      = data_width_p / 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [packet_width_lp-1:0]     data_i,
  output logic                           ready_o,
  output logic                           mem_v_o,
  output logic [addr_width_p-1:0]        mem_addr_o,
  output logic [data_width_p-1:0]        mem_data_o,
  output logic [mask_width_lp-1:0]       mem_mask_o,
  input  logic                           mem_yumi_i,
  output logic                           freeze_o,
  output logic [unknown_cnt_width_p-1:0] unknown_cnt_o
`ifdef BSG_MANYCORE_ENDPOINT_RETURN_CREDIT_EN
  ,
  output logic                           returning_v_o,
  output logic [x_cord_width_p-1:0]      returning_x_cord_o,
  output logic [y_cord_width_p-1:0]      returning_y_cord_o
`endif
);

  typedef struct packed {
    logic [op_width_gp-1:0]    op;
    logic [mask_width_lp-1:0]  op_ex;
    logic [addr_width_p-1:0]   addr;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] from_y_cord;
    logic [x_cord_width_p-1:0] from_x_cord;
  } packet_s;

  logic [packet_width_lp-1:0]     w_fifo_data;
  logic                           w_fifo_v;
  logic                           w_fifo_yumi;
  packet_s                        w_head;
  decode_e                        w_dec;
  logic                           r_freeze;
  logic [unknown_cnt_width_p-1:0] r_unknown_cnt;

  bsg_two_fifo #(
    .width_p(packet_width_lp)
  ) input_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (w_fifo_v),
    .data_o (w_fifo_data),
    .yumi_i (w_fifo_yumi)
  );

  assign w_head = packet_s'(w_fifo_data);

  // Gating with reset drops a stalled store in the very cycle reset is asserted.
  assign w_dec = decode_op(w_fifo_v & ~reset_i, w_head.op,
                           w_head.addr == addr_width_p'(config_freeze_addr_gp));

  assign mem_v_o     = (w_dec == e_dec_store);
  assign mem_addr_o  = w_head.addr;
  assign mem_data_o  = w_head.data;
  assign mem_mask_o  = w_head.op_ex;

  // Stores wait for the memory ack; config and unknown packets retire on arrival.
  assign w_fifo_yumi = mem_v_o ? mem_yumi_i : (w_dec != e_dec_none);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_freeze <= freeze_init_p;
    else if (w_dec == e_dec_config)
      r_freeze <= w_head.data[0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_unknown_cnt <= '0;
    else if ((w_dec == e_dec_unknown) && !(&r_unknown_cnt))
      r_unknown_cnt <= r_unknown_cnt + unknown_cnt_width_p'(1);
  end

  assign freeze_o      = r_freeze;
  assign unknown_cnt_o = r_unknown_cnt;

`ifdef BSG_MANYCORE_ENDPOINT_RETURN_CREDIT_EN
  logic                      r_returning_v;
  logic [x_cord_width_p-1:0] r_returning_x;
  logic [y_cord_width_p-1:0] r_returning_y;
  logic                      w_store_ack;

  assign w_store_ack = mem_v_o & mem_yumi_i;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_returning_v <= 1'b0;
    else
      r_returning_v <= w_store_ack;
  end

  always_ff @(posedge clk_i) begin
    if (w_store_ack) begin
      r_returning_x <= w_head.from_x_cord;
      r_returning_y <= w_head.from_y_cord;
    end
  end

  assign returning_v_o      = r_returning_v;
  assign returning_x_cord_o = r_returning_x;
  assign returning_y_cord_o = r_returning_y;
`endif

endmodule

// File: tb/tb_bsg_manycore_endpoint_store_unit.sv
// Self-checking bench for bsg_manycore_endpoint_store_unit using a store scoreboard.
module tb_bsg_manycore_endpoint_store_unit;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 8;
  localparam int MW = DW / 8;
  localparam int PW = 2 + MW + AW + DW + YW + XW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic [PW-1:0] data_i;
  logic          ready_o;
  logic          mem_v_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [MW-1:0] mem_mask_o;
  logic          mem_yumi_i;
  logic          freeze_o;
  logic [CW-1:0] unknown_cnt_o;
`ifdef BSG_MANYCORE_ENDPOINT_RETURN_CREDIT_EN
  logic          returning_v_o;
  logic [XW-1:0] returning_x_cord_o;
  logic [YW-1:0] returning_y_cord_o;
`endif

  bsg_manycore_endpoint_store_unit #(
    .x_cord_width_p     (XW),
    .y_cord_width_p     (YW),
    .data_width_p       (DW),
    .addr_width_p       (AW),
    .unknown_cnt_width_p(CW),
    .freeze_init_p      (1'b1)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .mem_v_o      (mem_v_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_mask_o   (mem_mask_o),
    .mem_yumi_i   (mem_yumi_i),
    .freeze_o     (freeze_o),
    .unknown_cnt_o(unknown_cnt_o)
`ifdef BSG_MANYCORE_ENDPOINT_RETURN_CREDIT_EN
    ,
    .returning_v_o     (returning_v_o),
    .returning_x_cord_o(returning_x_cord_o),
    .returning_y_cord_o(returning_y_cord_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Drives one packet (entered and left at posedge+1), holding it until accepted.
  task automatic drive_pkt(input logic [1:0] op, input logic [MW-1:0] op_ex,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [YW-1:0] y, input logic [XW-1:0] x);
    int n;
    exp_t e;
    n = 0;
    v_i = 1'b1;
    data_i = {op, op_ex, addr, data, y, x};
    @(negedge clk);
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL enqueue_timeout ready_o=%b required=1", ready_o);
    end else if (op == 2'd1) begin
      e.addr = addr; e.data = data; e.mask = op_ex; e.x = x; e.y = y;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic scoreboard_monitor();
    exp_t e;
    logic prev_ack;
`ifdef BSG_MANYCORE_ENDPOINT_RETURN_CREDIT_EN
    exp_t last;
`endif
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        prev_ack = 1'b0;
        continue;
      end
`ifdef BSG_MANYCORE_ENDPOINT_RETURN_CREDIT_EN
      vectors++;
      if (returning_v_o !== prev_ack) begin
        miscompares++;
        $display("FAIL returning_v got=%b required=%b", returning_v_o, prev_ack);
      end
      if (prev_ack) begin
        vectors++;
        if (returning_x_cord_o !== last.x || returning_y_cord_o !== last.y) begin
          miscompares++;
          $display("FAIL returning_cord got x=%0d y=%0d required x=%0d y=%0d",
                   returning_x_cord_o, returning_y_cord_o, last.x, last.y);
        end
      end
`endif
      prev_ack = 1'b0;
      if (mem_v_o === 1'b1 && mem_yumi_i === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_store addr=%h data=%h", mem_addr_o, mem_data_o);
        end else begin
          e = sb.pop_front();
          if (mem_addr_o !== e.addr || mem_data_o !== e.data || mem_mask_o !== e.mask) begin
            miscompares++;
            $display("FAIL store got addr=%h data=%h mask=%h required addr=%h data=%h mask=%h",
                     mem_addr_o, mem_data_o, mem_mask_o, e.addr, e.data, e.mask);
          end else begin
            $display("store ack addr=%h data=%h mask=%h", mem_addr_o, mem_data_o, mem_mask_o);
          end
          prev_ack = 1'b1;
`ifdef BSG_MANYCORE_ENDPOINT_RETURN_CREDIT_EN
          last = e;
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b required=1", ready_o); end
    vectors++;
    if (mem_v_o !== 1'b0) begin miscompares++; $display("FAIL reset_mem_v got=%b required=0", mem_v_o); end
    vectors++;
    if (freeze_o !== 1'b1) begin miscompares++; $display("FAIL reset_freeze got=%b required=1", freeze_o); end
    vectors++;
    if (unknown_cnt_o !== 8'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d required=0", unknown_cnt_o); end
    $display("reset done");
    @(posedge clk); #1;
  endtask

  task automatic test_single_store();
    mem_yumi_i = 1'b1;
    drive_pkt(2'd1, 4'hF, 10'h010, 32'hDEADBEEF, 4'd2, 4'd1);
    v_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_v_o !== 1'b1) begin miscompares++; $display("FAIL store_latency mem_v_o got=%b required=1", mem_v_o); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (mem_v_o !== 1'b0 || ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL store_drained mem_v_o=%b ready_o=%b required 0/1", mem_v_o, ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n;
    mem_yumi_i = 1'b0;
    drive_pkt(2'd1, 4'h3, 10'h021, 32'h11111111, 4'd0, 4'd1);
    drive_pkt(2'd1, 4'hC, 10'h022, 32'h22222222, 4'd1, 4'd2);
    v_i = 1'b1;
    data_i = {2'd1, 4'h5, 10'h023, 32'h33333333, 4'd2, 4'd3};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_full ready_o got=%b required=0", ready_o); end
      vectors++;
      if (mem_v_o !== 1'b1 || mem_addr_o !== 10'h021 || mem_data_o !== 32'h11111111 || mem_mask_o !== 4'h3) begin
        miscompares++;
        $display("FAIL b2b_stall_stable got v=%b addr=%h data=%h mask=%h required 1/021/11111111/3",
                 mem_v_o, mem_addr_o, mem_data_o, mem_mask_o);
      end
      @(posedge clk); #1;
    end
    mem_yumi_i = 1'b1;
    drive_pkt(2'd1, 4'h5, 10'h023, 32'h33333333, 4'd2, 4'd3);
    v_i = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    vectors++;
    if (sb.size() != 0 || mem_v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain pending=%0d mem_v_o=%b required 0/0", sb.size(), mem_v_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_config();
    logic [1:0] vals;
    vals = 2'b10;
    mem_yumi_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_pkt(2'd2, 4'h0, 10'h000, {31'd0, vals[k]}, 4'd1, 4'd1);
      v_i = 1'b0;
      @(negedge clk);
      vectors++;
      if (mem_v_o !== 1'b0) begin miscompares++; $display("FAIL config_no_mem mem_v_o got=%b required=0", mem_v_o); end
      vectors++;
      if (freeze_o !== ~vals[k]) begin miscompares++; $display("FAIL config_freeze_before got=%b required=%b", freeze_o, ~vals[k]); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (freeze_o !== vals[k]) begin miscompares++; $display("FAIL config_freeze_after got=%b required=%b", freeze_o, vals[k]); end
      $display("config freeze=%b", vals[k]);
      @(posedge clk); #1;
    end
    vectors++;
    if (unknown_cnt_o !== 8'd0) begin miscompares++; $display("FAIL config_cnt got=%0d required=0", unknown_cnt_o); end
  endtask

  task automatic test_unknown();
    mem_yumi_i = 1'b1;
    drive_pkt(2'd3, 4'h1, 10'h005, 32'h0, 4'd0, 4'd0);
    drive_pkt(2'd2, 4'h0, 10'h004, 32'h1, 4'd0, 4'd0);
    v_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (unknown_cnt_o !== 8'd2) begin miscompares++; $display("FAIL unknown_two got=%0d required=2", unknown_cnt_o); end
    vectors++;
    if (freeze_o !== 1'b1) begin miscompares++; $display("FAIL unknown_freeze got=%b required=1", freeze_o); end
    @(posedge clk); #1;
    for (int k = 0; k < 300; k++) begin
      drive_pkt((k % 2 == 0) ? 2'd0 : 2'd3, 4'h0, AW'(k + 1), 32'(k), 4'd0, 4'd0);
      if (k == 252) begin
        v_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (unknown_cnt_o !== 8'd255) begin miscompares++; $display("FAIL unknown_reach_max got=%0d required=255", unknown_cnt_o); end
        @(posedge clk); #1;
      end
    end
    v_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (unknown_cnt_o !== 8'd255) begin miscompares++; $display("FAIL unknown_saturate got=%0d required=255", unknown_cnt_o); end
    vectors++;
    if (mem_v_o !== 1'b0) begin miscompares++; $display("FAIL unknown_no_mem got=%b required=0", mem_v_o); end
    $display("unknown count=%0d", unknown_cnt_o);
    @(posedge clk); #1;
  endtask

  task automatic test_credit();
    mem_yumi_i = 1'b1;
    drive_pkt(2'd1, 4'h6, 10'h030, 32'hCAFEF00D, 4'd5, 4'd3);
    drive_pkt(2'd2, 4'h0, 10'h000, 32'h1, 4'd7, 4'd7);
    v_i = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL credit_drain pending=%0d required=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    mem_yumi_i = 1'b1;
    drive_pkt(2'd2, 4'h0, 10'h000, 32'h0, 4'd0, 4'd0);
    v_i = 1'b0;
    @(posedge clk); #1;
    mem_yumi_i = 1'b0;
    drive_pkt(2'd1, 4'hF, 10'h040, 32'hA5A5A5A5, 4'd1, 4'd1);
    drive_pkt(2'd1, 4'hF, 10'h041, 32'h5A5A5A5A, 4'd1, 4'd1);
    v_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_v_o !== 1'b1 || ready_o !== 1'b0 || freeze_o !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset got v=%b ready=%b freeze=%b required 1/0/0", mem_v_o, ready_o, freeze_o);
    end
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_v_o !== 1'b0) begin miscompares++; $display("FAIL reset_drop_store got=%b required=0", mem_v_o); end
    @(posedge clk); #1;
    reset_i = 1'b0;
    sb.delete();
    @(negedge clk);
    vectors++;
    if (mem_v_o !== 1'b0 || ready_o !== 1'b1 || freeze_o !== 1'b1 || unknown_cnt_o !== 8'd0) begin
      miscompares++;
      $display("FAIL post_reset got v=%b ready=%b freeze=%b cnt=%0d required 0/1/1/0",
               mem_v_o, ready_o, freeze_o, unknown_cnt_o);
    end
    $display("mid-operation reset done");
    @(posedge clk); #1;
  endtask

  initial begin
    reset_i = 1'b1;
    v_i = 1'b0;
    data_i = '0;
    mem_yumi_i = 1'b0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_single_store();
    test_back_to_back();
    test_config();
    test_unknown();
    test_credit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
